bit_packer: RTL and testbench

BIT_PACKER -- requirements
Module: bit_packer

---
 rtl/bit_packer.sv | 135 +++++++++++++
 tb/tb_bit_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_packer.sv
// Packs variable-length LSB-aligned fields into W-bit words, newest field in the higher bits.
// A flush request emits any partial word once all full words have drained.
module bit_packer #(
  parameter int unsigned W  = 16,
  parameter int unsigned LW = 5
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [LW-1:0] in_len,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] out_bits
);

  localparam int unsigned AW = 2 * W;
  localparam int unsigned CW = LW + 1;

  typedef enum logic [1:0] {FILL, DRAIN, FLUSH} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] acc, acc_nx;
  logic [LW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          flush_pend, pend_nx, pend_req;
  logic          reeval;
  logic [LW-1:0] eff_len;
  logic [AW-1:0] field_sh;
  logic          in_ready_nx, out_valid_nx;
  logic [W-1:0]  out_data_nx;
  logic [LW-1:0] out_bits_nx;

  // Ones in bit positions below n; n >= W yields all ones.
  function automatic logic [W-1:0] low_mask(input logic [CW-1:0] n);
    return ~({W{1'b1}} << n);
  endfunction

  // Clamp the requested length and place the masked field just above the held bits.
  always_comb begin
    eff_len  = (in_len > LW'(W)) ? LW'(W) : in_len;
    field_sh = AW'(in_data & low_mask(CW'(eff_len))) << cnt;
  end

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = CW'(cnt);
    pend_req = flush_pend | flush;
    pend_nx  = pend_req;
    reeval   = 1'b0;

    case (state)
      FILL: begin
        if (in_valid && (eff_len != '0)) begin
          acc_nx = acc | field_sh;
          cnt_nx = CW'(cnt) + CW'(eff_len);
        end
        reeval = 1'b1;
      end
      DRAIN: begin
        if (out_ready) begin
          acc_nx = acc >> W;
          cnt_nx = CW'(cnt) - CW'(W);
          reeval = 1'b1;
        end
      end
      FLUSH: begin
        if (out_ready) begin
          acc_nx   = '0;
          cnt_nx   = '0;
          pend_nx  = 1'b0;
          state_nx = FILL;
        end
      end
      default: begin
        state_nx = FILL;
        acc_nx   = '0;
        cnt_nx   = '0;
        pend_nx  = 1'b0;
      end
    endcase

    // Full words always go first; a pending flush only fires on a true remainder.
    if (reeval) begin
      if (cnt_nx >= CW'(W)) begin
        state_nx = DRAIN;
      end else if (pend_req && (cnt_nx != '0)) begin
        state_nx = FLUSH;
      end else begin
        state_nx = FILL;
        pend_nx  = 1'b0;
      end
    end

    in_ready_nx  = (state_nx == FILL);
    out_valid_nx = (state_nx != FILL);
    out_data_nx  = '0;
    out_bits_nx  = '0;
    if (state_nx == DRAIN) begin
      out_data_nx = acc_nx[W-1:0];
      out_bits_nx = LW'(W);
    end else if (state_nx == FLUSH) begin
      out_data_nx = acc_nx[W-1:0] & low_mask(cnt_nx);
      out_bits_nx = cnt_nx[LW-1:0];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= FILL;
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bits   <= '0;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      cnt        <= cnt_nx[LW-1:0];
      flush_pend <= pend_nx;
      in_ready   <= in_ready_nx;
      out_valid  <= out_valid_nx;
      out_data   <= out_data_nx;
      out_bits   <= out_bits_nx;
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer (W=16): vector table with random back-pressure plus directed corner sequences,
// all emitted words checked against an expected-word queue.
module tb_bit_packer;

  localparam int unsigned W  = 16;
  localparam int unsigned LW = 5;

  logic          clk = 1'b0;
  logic          arst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [LW-1:0] in_len;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [LW-1:0] out_bits;

  logic          rand_ready = 1'b0;
  logic          rnd_bit    = 1'b1;
  logic          man_ready  = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [LW-1:0] bits;
  } exp_t;

  typedef struct {
    logic [W-1:0]  d;
    logic [LW-1:0] l;
    logic          f;
    logic          has_word;
    logic [W-1:0]  w;
    logic [LW-1:0] b;
  } vec_t;

  exp_t exp_q[$];

  assign out_ready = rand_ready ? rnd_bit : man_ready;

  always #5 clk = ~clk;

  always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  bit_packer #(.W(W), .LW(LW)) dut (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bits  (out_bits)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completed output handshake must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!arst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word act=0x%0h/%0d exp=none at %0t", out_data, out_bits, $time);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", 32'(out_data), 32'(e.data));
        chk("word_bits", 32'(out_bits), 32'(e.bits));
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] d, input logic [LW-1:0] b);
    exp_t e;
    e.data = d;
    e.bits = b;
    exp_q.push_back(e);
  endtask

  // Offer one field; flush rides along only on the cycle the field is taken.
  task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l, input logic fl);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    flush    = fl && in_ready;
    while (!in_ready) begin
      @(posedge clk); #1;
      n++;
      flush = fl && in_ready;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout act=in_ready_low exp=accept at %0t", $time);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[16];
    vt[0]  = '{16'h000A, 5'd4,  1'b0, 1'b0, 16'h0000, 5'd0};
    vt[1]  = '{16'h0BCD, 5'd12, 1'b0, 1'b1, 16'hBCDA, 5'd16};
    vt[2]  = '{16'h0003, 5'd2,  1'b0, 1'b0, 16'h0000, 5'd0};
    vt[3]  = '{16'h0005, 5'd3,  1'b1, 1'b1, 16'h0017, 5'd5};
    vt[4]  = '{16'h0FFF, 5'd12, 1'b0, 1'b0, 16'h0000, 5'd0};
    vt[5]  = '{16'h00AB, 5'd8,  1'b0, 1'b1, 16'hBFFF, 5'd16};
    vt[6]  = '{16'hFFFF, 5'd0,  1'b1, 1'b1, 16'h000A, 5'd4};
    vt[7]  = '{16'h1234, 5'd0,  1'b0, 1'b0, 16'h0000, 5'd0};
    vt[8]  = '{16'hFFFF, 5'd31, 1'b0, 1'b1, 16'hFFFF, 5'd16};
    vt[9]  = '{16'h5555, 5'd0,  1'b1, 1'b0, 16'h0000, 5'd0};
    vt[10] = '{16'hFFD5, 5'd7,  1'b0, 1'b0, 16'h0000, 5'd0};
    vt[11] = '{16'h0012, 5'd9,  1'b0, 1'b1, 16'h0955, 5'd16};
    vt[12] = '{16'hF0F0, 5'd16, 1'b0, 1'b1, 16'hF0F0, 5'd16};
    vt[13] = '{16'h0003, 5'd3,  1'b0, 1'b0, 16'h0000, 5'd0};
    vt[14] = '{16'hABCD, 5'd16, 1'b0, 1'b1, 16'h5E6B, 5'd16};
    vt[15] = '{16'h0000, 5'd0,  1'b1, 1'b1, 16'h0005, 5'd3};

    arst     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_bits",  32'(out_bits),  32'd0);
    arst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Two fields fill exactly one word; valid must appear the cycle after the second accept.
    push_exp(16'hBCDA, 5'd16);
    send(16'h000A, 5'd4, 1'b0);
    chk("lat_before_valid", 32'(out_valid), 32'd0);
    send(16'h0BCD, 5'd12, 1'b0);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_in_ready",  32'(in_ready),  32'd0);
    wait_empty();

    // Back-pressure: second full field is stalled while the first word is held.
    man_ready = 1'b0;
    push_exp(16'hFFFF, 5'd16);
    push_exp(16'h1234, 5'd16);
    send(16'hFFFF, 5'd16, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    in_len   = 5'd16;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_out_data",  32'(out_data),  32'hFFFF);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    man_ready = 1'b1;
    send(16'h1234, 5'd16, 1'b0);
    wait_empty();

    // Separate flush pulse after a 5-bit partial, then a flush with nothing buffered.
    push_exp(16'h0017, 5'd5);
    send(16'h0003, 5'd2, 1'b0);
    send(16'h0005, 5'd3, 1'b0);
    pulse_flush();
    wait_empty();
    pulse_flush();
    repeat (4) @(posedge clk);
    #1;
    chk("empty_flush_valid", 32'(out_valid), 32'd0);

    // Flush arriving in DRAIN: full word first, then the 8-bit remainder.
    man_ready = 1'b0;
    push_exp(16'hCD0F, 5'd16);
    push_exp(16'h00AB, 5'd8);
    send(16'h000F, 5'd8, 1'b0);
    send(16'hABCD, 5'd16, 1'b0);
    pulse_flush();
    repeat (2) @(posedge clk);
    #1;
    chk("drain_flush_hold", 32'(out_data), 32'hCD0F);
    man_ready = 1'b1;
    wait_empty();

    // Vector table under random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (vt[i].has_word) push_exp(vt[i].w, vt[i].b);
      send(vt[i].d, vt[i].l, vt[i].f);
    end
    wait_empty();
    rand_ready = 1'b0;
    man_ready  = 1'b1;

    // Reset in DRAIN with 20 bits and a pending flush: nothing may survive.
    man_ready = 1'b0;
    send(16'h0005, 5'd4, 1'b0);
    send(16'hFFFF, 5'd16, 1'b0);
    pulse_flush();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    arst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data",  32'(out_data),  32'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    man_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_word", 32'(out_valid), 32'd0);
    push_exp(16'h0001, 5'd1);
    send(16'h0001, 5'd1, 1'b1);
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
